// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register sentinel and encoded lengths.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] R_NONE = 4'hF;

    localparam logic [3:0] LEN_SHORT = 4'd1;   // opcode byte only
    localparam logic [3:0] LEN_REG   = 4'd2;   // opcode + register byte
    localparam logic [3:0] LEN_DEST  = 4'd9;   // opcode + 8-byte destination
    localparam logic [3:0] LEN_FULL  = 4'd10;  // opcode + register byte + 8-byte constant

    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            I_CMOV, I_OP, I_PUSH, I_POP: instr_len = LEN_REG;
            I_JXX, I_CALL:               instr_len = LEN_DEST;
            I_IRMOV, I_RMMOV, I_MRMOV:   instr_len = LEN_FULL;
            default:                     instr_len = LEN_SHORT;
        endcase
    endfunction

endpackage

// File: rtl/y86_fetch_decode.sv
// Combinational fetch decode: field split, length, constant word, validity and status flags.
module y86_fetch_decode
    import y86_pkg::*;
#(
    parameter int IMEM_BYTES = 1024
) (
    input  logic [63:0] pc_i,
    input  logic [79:0] instruction_i,
    output logic [3:0]  icode_o,
    output logic [3:0]  ifun_o,
    output logic [3:0]  ra_o,
    output logic [3:0]  rb_o,
    output logic [63:0] valc_o,
    output logic [63:0] valp_o,
    output logic        ins_o,
    output logic        adr_o,
    output logic        hlt_o
);

    logic [7:0]  ibyte [10];
    logic        valid;
    logic        has_reg;
    logic [3:0]  len;
    logic [63:0] last_addr;

    // NOTE: every output of this block gets a value before any branch, so no latch can be inferred.
    always_comb begin
        for (int k = 0; k < 10; k++) begin
            ibyte[k] = instruction_i[79 - 8*k -: 8];
        end

        icode_o = ibyte[0][7:4];
        ifun_o  = ibyte[0][3:0];

        case (icode_o)
            I_CMOV, I_JXX:                         valid = (ifun_o <= 4'd6);
            I_OP:                                  valid = (ifun_o <= 4'd3);
            I_HALT, I_NOP, I_IRMOV, I_RMMOV,
            I_MRMOV, I_CALL, I_RET, I_PUSH, I_POP: valid = (ifun_o == 4'd0);
            default:                               valid = 1'b0;
        endcase

        case (icode_o)
            I_CMOV, I_IRMOV, I_RMMOV, I_MRMOV,
            I_OP, I_PUSH, I_POP: has_reg = 1'b1;
            default:             has_reg = 1'b0;
        endcase

        // An invalid opcode is treated as a bare 1-byte instruction with no operands.
        len    = valid ? instr_len(icode_o) : LEN_SHORT;
        ra_o   = (valid && has_reg) ? ibyte[1][7:4] : R_NONE;
        rb_o   = (valid && has_reg) ? ibyte[1][3:0] : R_NONE;
        valc_o = '0;
        if (valid) begin
            case (icode_o)
                I_IRMOV, I_RMMOV, I_MRMOV:
                    valc_o = {ibyte[9], ibyte[8], ibyte[7], ibyte[6],
                              ibyte[5], ibyte[4], ibyte[3], ibyte[2]};
                I_JXX, I_CALL:
                    valc_o = {ibyte[8], ibyte[7], ibyte[6], ibyte[5],
                              ibyte[4], ibyte[3], ibyte[2], ibyte[1]};
                default: valc_o = '0;
            endcase
        end

        valp_o    = pc_i + 64'(len);
        last_addr = valp_o - 64'd1;
        adr_o     = (pc_i >= 64'(IMEM_BYTES)) || (last_addr >= 64'(IMEM_BYTES));
        ins_o     = !valid && !adr_o;
        hlt_o     = (icode_o == I_HALT) && (ifun_o == 4'd0) && !adr_o;
    end

endmodule

// File: rtl/y86_fetch.sv
// SEQ Y86-64 fetch stage: decodes PC/instruction window and registers the results each cycle.
module y86_fetch
    import y86_pkg::*;
#(
    parameter int IMEM_BYTES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [63:0]        PC,
    input  logic [79:0]        Instruction,
    output logic [3:0]         icode,
    output logic [3:0]         ifun,
    output logic [3:0]         rA,
    output logic [3:0]         rB,
    output logic signed [63:0] valC,
    output logic signed [63:0] valP,
    output logic               INS,
    output logic               ADR,
    output logic               HLT
);

    logic [3:0]  icode_d, ifun_d, ra_d, rb_d;
    logic [63:0] valc_d, valp_d;
    logic        ins_d, adr_d, hlt_d;

    logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
    logic [63:0] valc_q, valp_q;
    logic        ins_q, adr_q, hlt_q;

    y86_fetch_decode #(
        .IMEM_BYTES(IMEM_BYTES)
    ) u_decode (
        .pc_i          (PC),
        .instruction_i (Instruction),
        .icode_o       (icode_d),
        .ifun_o        (ifun_d),
        .ra_o          (ra_d),
        .rb_o          (rb_d),
        .valc_o        (valc_d),
        .valp_o        (valp_d),
        .ins_o         (ins_d),
        .adr_o         (adr_d),
        .hlt_o         (hlt_d)
    );

    // NOTE: non-blocking assignments keep every register sampling pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            icode_q <= I_HALT;
            ifun_q  <= 4'd0;
            ra_q    <= R_NONE;
            rb_q    <= R_NONE;
            valc_q  <= '0;
            valp_q  <= '0;
            ins_q   <= 1'b0;
            adr_q   <= 1'b0;
            hlt_q   <= 1'b0;
        end else begin
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
            ins_q   <= ins_d;
            adr_q   <= adr_d;
            hlt_q   <= hlt_d;
        end
    end

    assign icode = icode_q;
    assign ifun  = ifun_q;
    assign rA    = ra_q;
    assign rB    = rb_q;
    assign valC  = valc_q;
    assign valP  = valp_q;
    assign INS   = ins_q;
    assign ADR   = adr_q;
    assign HLT   = hlt_q;

endmodule

// File: tb/tb_y86_fetch.sv
// Directed bench for y86_fetch: expected results queued at drive time, checked one edge later.
module tb_y86_fetch;

    localparam int IMEM = 1024;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        ins;
        logic        adr;
        logic        hlt;
    } fetch_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [63:0]        PC;
    logic [79:0]        Instruction;
    logic [3:0]         icode, ifun, rA, rB;
    logic signed [63:0] valC, valP;
    logic               INS, ADR, HLT;

    int tests  = 0;
    int failed = 0;

    fetch_t sb_q[$];
    fetch_t reset_val;

    y86_fetch #(.IMEM_BYTES(IMEM)) dut (
        .clk         (clk),
        .rst         (rst),
        .PC          (PC),
        .Instruction (Instruction),
        .icode       (icode),
        .ifun        (ifun),
        .rA          (rA),
        .rB          (rB),
        .valC        (valC),
        .valP        (valP),
        .INS         (INS),
        .ADR         (ADR),
        .HLT         (HLT)
    );

    always #5 clk = ~clk;

    function automatic fetch_t exp_of(input logic [3:0] ic, input logic [3:0] fn,
                                      input logic [3:0] ra, input logic [3:0] rb,
                                      input logic [63:0] vc, input logic [63:0] vp,
                                      input logic ins, input logic adr, input logic hlt);
        exp_of = '{icode: ic, ifun: fn, ra: ra, rb: rb, valc: vc, valp: vp,
                   ins: ins, adr: adr, hlt: hlt};
    endfunction

    function automatic fetch_t observed();
        observed = '{icode: icode, ifun: ifun, ra: rA, rb: rB, valc: valC, valp: valP,
                     ins: INS, adr: ADR, hlt: HLT};
    endfunction

    task automatic check(input string tag, input fetch_t exp);
        fetch_t obs;
        obs = observed();
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h I/A/H=%b%b%b, expected icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h I/A/H=%b%b%b",
                   tag, obs.icode, obs.ifun, obs.ra, obs.rb, obs.valc, obs.valp, obs.ins, obs.adr, obs.hlt,
                   exp.icode, exp.ifun, exp.ra, exp.rb, exp.valc, exp.valp, exp.ins, exp.adr, exp.hlt);
        end
    endtask

    // Drive one fetch, queue its expectation, then pop and compare after the edge.
    task automatic step(input string tag, input logic r, input logic [63:0] pc,
                        input logic [79:0] instr, input fetch_t exp);
        fetch_t e;
        @(negedge clk);
        rst         = r;
        PC          = pc;
        Instruction = instr;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            tests++;
            failed++;
            $error("FAIL %s: scoreboard empty, observed nothing expected", tag);
        end else begin
            e = sb_q.pop_front();
            check(tag, e);
        end
    endtask

    initial begin
        reset_val = exp_of(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        PC = 64'h0;
        Instruction = 80'h0;
        @(posedge clk);
        #1;
        check("reset", reset_val);

        // Inputs change but outputs must hold until the next edge.
        @(negedge clk);
        rst         = 1'b0;
        Instruction = 80'h3075239bce834dab49ec;
        #1;
        check("pre_edge_hold", reset_val);

        step("irmovq", 1'b0, 64'd0, 80'h3075239bce834dab49ec,
             exp_of(4'h3, 4'h0, 4'h7, 4'h5, 64'hEC49AB4D83CE9B23, 64'd10, 1'b0, 1'b0, 1'b0));
        step("jxx", 1'b0, 64'd0, 80'h708ef729cba74d6c92bc,
             exp_of(4'h7, 4'h0, 4'hF, 4'hF, 64'h926C4DA7CB29F78E, 64'd9, 1'b0, 1'b0, 1'b0));
        step("opq", 1'b0, 64'd0, 80'h608e0000000000000000,
             exp_of(4'h6, 4'h0, 4'h8, 4'hE, 64'h0, 64'd2, 1'b0, 1'b0, 1'b0));
        step("nop", 1'b0, 64'd0, 80'h10480000000000000000,
             exp_of(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 1'b0, 1'b0, 1'b0));
        step("halt", 1'b0, 64'd0, 80'h00AD0000000000000000,
             exp_of(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 1'b0, 1'b0, 1'b1));
        step("ret", 1'b0, 64'd0, 80'h90790000000000000000,
             exp_of(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 1'b0, 1'b0, 1'b0));
        step("mrmovq", 1'b0, 64'h100, 80'h50121122334455667788,
             exp_of(4'h5, 4'h0, 4'h1, 4'h2, 64'h8877665544332211, 64'h10A, 1'b0, 1'b0, 1'b0));
        step("call", 1'b0, 64'h20, 80'h80112233445566778800,
             exp_of(4'h8, 4'h0, 4'hF, 4'hF, 64'h8877665544332211, 64'h29, 1'b0, 1'b0, 1'b0));
        step("cmov_le", 1'b0, 64'h40, 80'h26340000000000000000,
             exp_of(4'h2, 4'h6, 4'h3, 4'h4, 64'h0, 64'h42, 1'b0, 1'b0, 1'b0));
        step("push_bad_fn", 1'b0, 64'd0, 80'hA18cecbd5b375a85c869,
             exp_of(4'hA, 4'h1, 4'hF, 4'hF, 64'h0, 64'd1, 1'b1, 1'b0, 1'b0));
        step("cmov_bad_fn", 1'b0, 64'd0, 80'h27840000000000000000,
             exp_of(4'h2, 4'h7, 4'hF, 4'hF, 64'h0, 64'd1, 1'b1, 1'b0, 1'b0));
        step("op_bad_fn", 1'b0, 64'd0, 80'h64120000000000000000,
             exp_of(4'h6, 4'h4, 4'hF, 4'hF, 64'h0, 64'd1, 1'b1, 1'b0, 1'b0));
        step("icode_c", 1'b0, 64'd0, 80'hC0000000000000000000,
             exp_of(4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 1'b1, 1'b0, 1'b0));
        step("irmovq_fits", 1'b0, 64'd1014, 80'h30F30102030405060708,
             exp_of(4'h3, 4'h0, 4'hF, 4'h3, 64'h0807060504030201, 64'd1024, 1'b0, 1'b0, 1'b0));
        step("adr_at_end", 1'b0, 64'd1024, 80'h10000000000000000000,
             exp_of(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1025, 1'b0, 1'b1, 1'b0));
        step("adr_over_halt", 1'b0, 64'd1024, 80'h00000000000000000000,
             exp_of(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1025, 1'b0, 1'b1, 1'b0));
        step("adr_crossing", 1'b0, 64'd1022, 80'h30F30102030405060708,
             exp_of(4'h3, 4'h0, 4'hF, 4'h3, 64'h0807060504030201, 64'd1032, 1'b0, 1'b1, 1'b0));
        step("invalid_last_byte", 1'b0, 64'd1023, 80'hC0000000000000000000,
             exp_of(4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1024, 1'b1, 1'b0, 1'b0));
        step("adr_over_ins", 1'b0, 64'd1024, 80'hC0000000000000000000,
             exp_of(4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1025, 1'b0, 1'b1, 1'b0));
        step("pre_reset", 1'b0, 64'd0, 80'h3075239bce834dab49ec,
             exp_of(4'h3, 4'h0, 4'h7, 4'h5, 64'hEC49AB4D83CE9B23, 64'd10, 1'b0, 1'b0, 1'b0));
        step("mid_reset", 1'b1, 64'd0, 80'h3075239bce834dab49ec, reset_val);
        step("after_reset", 1'b0, 64'd0, 80'h00AD0000000000000000,
             exp_of(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 1'b0, 1'b0, 1'b1));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
